cache_fill_fsm: RTL and testbench

- Miss-handling controller between the pipeline's I/D caches and the shared multi-cycle main memory.
- On a miss, fetches the whole block one word per cycle, writes each returned word into the cache data array, then writes the tag.
- Holds the pipeline stall while the fill is in progress.
- Its memory request/response signals are what the phase-3 bench traces as MemRead/MemAddress/MemDataOut.

---
 rtl/cache_fill_fsm.sv | 141 ++++++++++++++
 tb/tb_cache_fill_fsm.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams one block from main memory into the data array, then writes the tag.
// Optional perf counters (miss_count, stall_cycles) are built when CACHE_FILL_PERF_CNT_EN is defined.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int ADDR_W          = 16,
    localparam int SEL_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              write_data_array,
    output logic [SEL_W-1:0]  data_word_sel,
    output logic              write_tag_array,
    output logic              fill_done
`ifdef CACHE_FILL_PERF_CNT_EN
   ,output logic [15:0]       miss_count,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [SEL_W-1:0]  LAST_ISS  = SEL_W'(WORDS_PER_BLOCK - 1);
    localparam logic [SEL_W-1:0]  ISS_ONE   = SEL_W'(1);
    localparam logic [SEL_W:0]    RECV_FULL = (SEL_W + 1)'(WORDS_PER_BLOCK);
    localparam logic [SEL_W:0]    RECV_ONE  = (SEL_W + 1)'(1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    issue_q, issue_d;
    logic [SEL_W:0]      recv_q, recv_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                take_ret;

    // Data words go straight from memory to the array; latency only matters to the memory side.
    logic unused_inputs;
    assign unused_inputs = ^{memory_data, 32'(MEM_LATENCY)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            issue_q <= '0;
            recv_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        issue_d          = issue_q;
        recv_d           = recv_q;
        base_d           = base_q;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        mem_addr         = '0;
        write_data_array = 1'b0;
        data_word_sel    = recv_q[SEL_W-1:0];
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        take_ret         = 1'b0;

        // Returns are accepted only while a fill is open and the block is not yet complete.
        if ((state_q == S_FILL || state_q == S_DRAIN) && memory_data_valid && recv_q != RECV_FULL) begin
            take_ret         = 1'b1;
            write_data_array = 1'b1;
            recv_d           = recv_q + RECV_ONE;
        end

        case (state_q)
            S_IDLE: begin
                // rst_n gating keeps the stall low while reset is held with a pending miss.
                if (miss_detected && rst_n) begin
                    fsm_busy = 1'b1;
                    base_d   = miss_address & BASE_MASK;
                    issue_d  = '0;
                    recv_d   = '0;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                fsm_busy = 1'b1;
                mem_en   = 1'b1;
                mem_addr = base_q + (ADDR_W'(issue_q) << 1);
                issue_d  = issue_q + ISS_ONE;
                if (issue_q == LAST_ISS) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                fsm_busy = 1'b1;
                if (recv_d == RECV_FULL) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                fill_done       = 1'b1;
                issue_d         = '0;
                recv_d          = '0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CACHE_FILL_PERF_CNT_EN
    logic [15:0] miss_count_q;
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (state_q == S_IDLE && miss_detected && miss_count_q != '1) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
            if (fsm_busy && stall_cycles_q != '1) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign miss_count   = miss_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: a latency-configurable memory model plus a per-cycle expected trace.
module tb_cache_fill_fsm;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [15:0] memory_data = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy, mem_en, write_data_array, write_tag_array, fill_done;
    logic [15:0] mem_addr;
    logic [2:0]  data_word_sel;
`ifdef CACHE_FILL_PERF_CNT_EN
    logic [15:0] miss_count;
    logic [31:0] stall_cycles;
`endif

    cache_fill_fsm dut (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
        .mem_en(mem_en), .mem_addr(mem_addr), .write_data_array(write_data_array),
        .data_word_sel(data_word_sel), .write_tag_array(write_tag_array), .fill_done(fill_done)
`ifdef CACHE_FILL_PERF_CNT_EN
       ,.miss_count(miss_count), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Trace bits per cycle: {mem_en, write_data_array, write_tag_array, fill_done, fsm_busy}
    logic [4:0]  t_ctl[64], e_ctl[64];
    logic [15:0] t_addr[64], e_addr[64], t_data[64], e_data[64];
    logic [2:0]  t_sel[64], e_sel[64];
    logic        miss_tab[64], xv_tab[64];
    logic [15:0] maddr_tab[64];
    logic        rv[128];
    logic [15:0] rd[128];
    int          lat;
    logic [15:0] dkey;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return dkey + ((a & 16'h000E) >> 1);
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < 64; c++) begin
            miss_tab[c] = 1'b0; xv_tab[c] = 1'b0; maddr_tab[c] = '0;
            e_ctl[c] = '0; e_addr[c] = '0; e_sel[c] = '0; e_data[c] = '0;
        end
    endtask

    task automatic set_miss(input int s, input int e, input logic [15:0] a);
        for (int c = s; c <= e; c++) begin
            miss_tab[c] = 1'b1; maddr_tab[c] = a;
        end
    endtask

    // One fill starting at cycle s: W back-to-back issues, each return lat cycles later, DONE after the last return.
    task automatic add_fill(input int s, input logic [15:0] a);
        logic [15:0] base;
        int d;
        base = a & ~16'(2 * W - 1);
        d = s + W + lat + 1;
        for (int c = s; c <= d; c++) e_ctl[c][0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            e_ctl[s + 1 + i][4] = 1'b1;
            e_addr[s + 1 + i] = base + 16'(2 * i);
            e_ctl[s + 1 + i + lat][3] = 1'b1;
            e_sel[s + 1 + i + lat] = 3'(i);
            e_data[s + 1 + i + lat] = mem_word(base + 16'(2 * i));
        end
        e_ctl[d][2] = 1'b1;
        e_ctl[d][1] = 1'b1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < 128; c++) begin rv[c] = 1'b0; rd[c] = '0; end
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            miss_detected = miss_tab[c];
            miss_address  = maddr_tab[c];
            if (rv[c]) begin
                memory_data_valid = 1'b1; memory_data = rd[c];
            end else if (xv_tab[c]) begin
                memory_data_valid = 1'b1; memory_data = 16'hDEAD;
            end else begin
                memory_data_valid = 1'b0; memory_data = 16'($urandom);
            end
            #1;
            t_ctl[c]  = {mem_en, write_data_array, write_tag_array, fill_done, fsm_busy};
            t_addr[c] = mem_addr;
            t_sel[c]  = data_word_sel;
            t_data[c] = memory_data;
            if (mem_en && c + lat < 128) begin
                rv[c + lat] = 1'b1;
                rd[c + lat] = mem_word(mem_addr);
            end
        end
        @(negedge clk);
        miss_detected = 1'b0; miss_address = '0; memory_data_valid = 1'b0; memory_data = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        miss_detected = 1'b1; miss_address = 16'h1234; memory_data_valid = 1'b1;
        #1;
        total++;
        if ({fsm_busy, mem_en, mem_addr, write_data_array, data_word_sel, write_tag_array, fill_done} !== '0) begin
            bad++;
            $display("FAIL reset_held got busy=%b en=%b addr=%h wr=%b sel=%0d tag=%b done=%b required all 0",
                     fsm_busy, mem_en, mem_addr, write_data_array, data_word_sel, write_tag_array, fill_done);
        end
        @(negedge clk);
        miss_detected = 1'b0; miss_address = '0; memory_data_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({fsm_busy, mem_en, mem_addr, write_data_array, data_word_sel, write_tag_array, fill_done} !== '0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b en=%b addr=%h wr=%b tag=%b done=%b required all 0",
                     fsm_busy, mem_en, mem_addr, write_data_array, write_tag_array, fill_done);
        end
`ifdef CACHE_FILL_PERF_CNT_EN
        total++;
        if (miss_count !== 16'd0 || stall_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf got miss_count=%0d stall=%0d required 0 0", miss_count, stall_cycles);
        end
`endif
    endtask

    task automatic test_basic();
        clear_stim(); lat = 4; dkey = 16'hA000;
        set_miss(0, 13, 16'h1234);
        add_fill(0, 16'h1234);
        run(16);
        for (int c = 0; c < 16; c++) begin
            total++;
            if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL basic_ctl c=%0d got=%b required=%b", c, t_ctl[c], e_ctl[c]); end
            if (e_ctl[c][4]) begin total++;
                if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL basic_addr c=%0d got=%h required=%h", c, t_addr[c], e_addr[c]); end
            end
            if (e_ctl[c][3]) begin total++;
                if ({t_sel[c], t_data[c]} !== {e_sel[c], e_data[c]}) begin bad++;
                    $display("FAIL basic_wr c=%0d got sel=%0d data=%h required sel=%0d data=%h", c, t_sel[c], t_data[c], e_sel[c], e_data[c]); end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        int n;
        for (int k = 0; k < 4; k++) begin
            clear_stim(); lat = int'($urandom_range(1, 6)); dkey = 16'($urandom);
            a = 16'($urandom);
            set_miss(0, W + lat + 1, a);
            add_fill(0, a);
            n = W + lat + 4;
            run(n);
            for (int c = 0; c < n; c++) begin
                total++;
                if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL rand_ctl k=%0d lat=%0d c=%0d got=%b required=%b", k, lat, c, t_ctl[c], e_ctl[c]); end
                if (e_ctl[c][4]) begin total++;
                    if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL rand_addr k=%0d c=%0d got=%h required=%h", k, c, t_addr[c], e_addr[c]); end
                end
                if (e_ctl[c][3]) begin total++;
                    if ({t_sel[c], t_data[c]} !== {e_sel[c], e_data[c]}) begin bad++;
                        $display("FAIL rand_wr k=%0d c=%0d got sel=%0d data=%h required sel=%0d data=%h", k, c, t_sel[c], t_data[c], e_sel[c], e_data[c]); end
                end
            end
        end
    endtask

    task automatic test_top_block();
        clear_stim(); lat = int'($urandom_range(1, 6)); dkey = 16'($urandom);
        set_miss(0, W + lat + 1, 16'hFFFE);
        add_fill(0, 16'hFFFE);
        run(W + lat + 4);
        for (int c = 0; c < W + lat + 4; c++) begin
            total++;
            if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL top_ctl c=%0d got=%b required=%b", c, t_ctl[c], e_ctl[c]); end
            if (e_ctl[c][4]) begin total++;
                if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL top_addr c=%0d got=%h required=%h", c, t_addr[c], e_addr[c]); end
            end
            if (e_ctl[c][3]) begin total++;
                if (t_sel[c] !== e_sel[c]) begin bad++; $display("FAIL top_sel c=%0d got=%0d required=%0d", c, t_sel[c], e_sel[c]); end
            end
        end
    endtask

    task automatic test_miss_during_fill();
        int issued;
        clear_stim(); lat = 4; dkey = 16'h5100;
        set_miss(0, 2, 16'h1234);
        set_miss(3, 13, 16'h2000);
        add_fill(0, 16'h1234);
        run(18);
        issued = 0;
        for (int c = 0; c < 18; c++) begin
            if (t_ctl[c][4]) issued++;
            total++;
            if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL remiss_ctl c=%0d got=%b required=%b", c, t_ctl[c], e_ctl[c]); end
            if (e_ctl[c][4]) begin total++;
                if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL remiss_addr c=%0d got=%h required=%h", c, t_addr[c], e_addr[c]); end
            end
        end
        total++;
        if (issued !== W) begin bad++; $display("FAIL remiss_count got=%0d required=%0d", issued, W); end
    endtask

    task automatic test_spurious_valid();
        clear_stim(); lat = 4; dkey = 16'h7700;
        set_miss(2, 15, 16'h3458);
        add_fill(2, 16'h3458);
        xv_tab[0] = 1'b1; xv_tab[1] = 1'b1; xv_tab[15] = 1'b1; xv_tab[16] = 1'b1;
        run(18);
        for (int c = 0; c < 18; c++) begin
            total++;
            if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL spur_ctl c=%0d got=%b required=%b", c, t_ctl[c], e_ctl[c]); end
            if (e_ctl[c][3]) begin total++;
                if ({t_sel[c], t_data[c]} !== {e_sel[c], e_data[c]}) begin bad++;
                    $display("FAIL spur_wr c=%0d got sel=%0d data=%h required sel=%0d data=%h", c, t_sel[c], t_data[c], e_sel[c], e_data[c]); end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int wrs;
        clear_stim(); lat = 4; dkey = 16'h3300;
        set_miss(0, 13, 16'h4566);
        add_fill(0, 16'h4566);
        run(8);
        wrs = 0;
        for (int c = 0; c < 8; c++) begin
            if (t_ctl[c][3]) wrs++;
            total++;
            if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL abort_pre c=%0d got=%b required=%b", c, t_ctl[c], e_ctl[c]); end
        end
        total++;
        if (wrs !== 3) begin bad++; $display("FAIL abort_words got=%0d required=3", wrs); end
        miss_detected = 1'b1; miss_address = 16'h4566; memory_data_valid = 1'b1; rst_n = 1'b0;
        #1;
        total++;
        if ({fsm_busy, mem_en, mem_addr, write_data_array, data_word_sel, write_tag_array, fill_done} !== '0) begin
            bad++;
            $display("FAIL abort_outputs got busy=%b en=%b addr=%h wr=%b sel=%0d tag=%b done=%b required all 0",
                     fsm_busy, mem_en, mem_addr, write_data_array, data_word_sel, write_tag_array, fill_done);
        end
        repeat (2) begin
            @(negedge clk); #1;
            total++;
            if (write_tag_array !== 1'b0 || fill_done !== 1'b0) begin
                bad++; $display("FAIL abort_tag got tag=%b done=%b required 0 0", write_tag_array, fill_done);
            end
        end
        @(negedge clk);
        miss_detected = 1'b0; memory_data_valid = 1'b0; rst_n = 1'b1;
        clear_stim(); dkey = 16'h9900;
        set_miss(1, 14, 16'h4566);
        add_fill(1, 16'h4566);
        run(17);
        for (int c = 0; c < 17; c++) begin
            total++;
            if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL restart_ctl c=%0d got=%b required=%b", c, t_ctl[c], e_ctl[c]); end
            if (e_ctl[c][3]) begin total++;
                if ({t_sel[c], t_data[c]} !== {e_sel[c], e_data[c]}) begin bad++;
                    $display("FAIL restart_wr c=%0d got sel=%0d data=%h required sel=%0d data=%h", c, t_sel[c], t_data[c], e_sel[c], e_data[c]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_stim(); lat = 4; dkey = 16'($urandom);
        a = 16'($urandom);
        set_miss(0, 27, a);
        add_fill(0, a);
        add_fill(14, a);
        run(30);
        for (int c = 0; c < 30; c++) begin
            total++;
            if (t_ctl[c] !== e_ctl[c]) begin bad++; $display("FAIL b2b_ctl c=%0d got=%b required=%b", c, t_ctl[c], e_ctl[c]); end
            if (e_ctl[c][4]) begin total++;
                if (t_addr[c] !== e_addr[c]) begin bad++; $display("FAIL b2b_addr c=%0d got=%h required=%h", c, t_addr[c], e_addr[c]); end
            end
        end
`ifdef CACHE_FILL_PERF_CNT_EN
        #1;
        total++;
        if (miss_count !== 16'd2 || stall_cycles !== 32'd28) begin
            bad++; $display("FAIL b2b_perf got miss_count=%0d stall=%0d required 2 28", miss_count, stall_cycles);
        end
`endif
    endtask

    initial begin
        lat = 4; dkey = '0;
        clear_stim();
        test_reset();
        test_basic();
        test_random();
        test_top_block();
        test_miss_during_fill();
        test_spurious_valid();
        test_reset_mid_fill();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
